// File: rtl/arith_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtract and shift per clock,
// with a start/busy/done handshake and registered, held results.
module arith_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   p_step_s;
    logic [WIDTH-1:0] q_step_s;

    // One restoring step: shift {P,Q} left, trial-subtract, keep or restore P.
    always_comb begin
        shifted_s = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor_q};
        if (trial_s[WIDTH] == 1'b0) begin
            p_step_s = trial_s;
            q_step_s = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            p_step_s = shifted_s;
            q_step_s = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Handshake FSM and next-state of datapath and result registers.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start == 1'b1) begin
                    divisor_d = divisor;
                    q_d       = dividend;
                    p_d       = {(WIDTH + 1){1'b0}};
                    cnt_d     = CNT_ZERO;
                    // A zero divisor skips the iteration and reports immediately.
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d     = ST_FINISH;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d   = p_step_s;
                q_d   = q_step_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_FINISH;
                    quotient_d  = q_step_s;
                    remainder_d = p_step_s[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            p_q         <= {(WIDTH + 1){1'b0}};
            q_q         <= {WIDTH{1'b0}};
            divisor_q   <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
